// File: rtl/halfduplex_port.sv
// Half-duplex tristate pad port: one command at a time, write drive with bus turnaround, read sample.
// Optional macro HALFDUPLEX_PORT_SYNC_EN puts a 2-flop synchronizer on the pad input.
module halfduplex_port #(
  parameter int unsigned N  = 8,
  parameter int unsigned TA = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [N-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         strobe,
  output logic [N-1:0] oe,
  output logic [N-1:0] out,
  input  logic [N-1:0] in
);

  localparam int unsigned CNT_W = 4;
`ifdef HALFDUPLEX_PORT_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 1;
`endif
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TA - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, TURN, RD_STROBE, RD_WAIT, RD_RSP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     sync_q;
  logic [N-1:0]     oe_n, out_n, rsp_data_n;
  logic             strobe_n, cmd_ready_n, rsp_valid_n;
  logic             accept, drive_n;

  // Pad input capture
`ifdef HALFDUPLEX_PORT_SYNC_EN
  logic [N-1:0] sync_meta;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= in;
      sync_q    <= sync_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= in;
  end
`endif

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      oe        <= '0;
      out       <= '0;
      strobe    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      oe        <= oe_n;
      out       <= out_n;
      strobe    <= strobe_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
    end
  end

  // Next state; outputs are decoded from the next state so they are valid in the state's own cycle
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rsp_data_n  = rsp_data;
    oe_n        = '0;
    out_n       = '0;
    strobe_n    = 1'b0;
    cmd_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
    drive_n     = 1'b0;
    accept      = cmd_valid & cmd_ready;

    case (state)
      IDLE:      if (accept) state_n = cmd_write ? WR_SETUP : RD_STROBE;
      WR_SETUP:  state_n = WR_STROBE;
      WR_STROBE: state_n = WR_HOLD;
      WR_HOLD: begin
        state_n = TURN;
        cnt_n   = TURN_LOAD;
      end
      TURN: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = CNT_W'(cnt - 1'b1);
      end
      RD_STROBE: begin
        state_n = RD_WAIT;
        cnt_n   = WAIT_LOAD;
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_n    = RD_RSP;
          rsp_data_n = sync_q;
        end else begin
          cnt_n = CNT_W'(cnt - 1'b1);
        end
      end
      RD_RSP:    if (rsp_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    drive_n     = (state_n == WR_SETUP) || (state_n == WR_STROBE) || (state_n == WR_HOLD);
    oe_n        = drive_n ? '1 : '0;
    strobe_n    = (state_n == WR_STROBE) || (state_n == RD_STROBE);
    cmd_ready_n = (state_n == IDLE);
    rsp_valid_n = (state_n == RD_RSP);

    // out doubles as the write-data latch: loaded on acceptance, held while driving
    if (state == IDLE && accept && cmd_write) out_n = cmd_data;
    else if (drive_n)                         out_n = out;
  end

endmodule
